rfid_nios_cpu_div_cell: RTL

Iterative radix-2 integer divider for the Nios II custom-arithmetic path. It is the inverse-operation companion to the three-partial-product multiplier cell. It accepts a dividend/divisor pair from the E stage and produces quotient and remainder after a fixed, known latency. The M/W-stage stall logic reads the start/busy/done handshake.

---
 rtl/rfid_nios_cpu_div_cell_if.sv | 24 ++
 rtl/rfid_nios_cpu_div_cell.sv | 102 ++++++++++
 2 files changed

// File: rtl/rfid_nios_cpu_div_cell_if.sv
// Handshake and operand/result bundle between the E/M stages and the divider cell.
// master drives the request side; slave is the divider.
interface rfid_nios_cpu_div_cell_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] E_src1;
    logic [WIDTH-1:0] E_src2;
    logic             E_start;
    logic             E_signed;
    logic             M_abort;
    logic [WIDTH-1:0] M_div_quot;
    logic [WIDTH-1:0] M_div_rem;
    logic             M_div_busy;
    logic             M_div_done;
    logic             M_div_by_zero;

    modport master (
        output E_src1, E_src2, E_start, E_signed, M_abort,
        input  M_div_quot, M_div_rem, M_div_busy, M_div_done, M_div_by_zero
    );

    modport slave (
        input  E_src1, E_src2, E_start, E_signed, M_abort,
        output M_div_quot, M_div_rem, M_div_busy, M_div_done, M_div_by_zero
    );
endinterface

// File: rtl/rfid_nios_cpu_div_cell.sv
// Iterative radix-2 restoring divider: WIDTH+2 cycles start-to-done,
// signed/unsigned, truncating division, divide-by-zero short path.
module rfid_nios_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    rfid_nios_cpu_div_cell_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd, dsr, rem;
    logic [WIDTH-1:0] quot_r, rem_r;
    logic             q_neg, r_neg, dbz, dbz_r;
    logic [WIDTH-1:0] src1_mag, src2_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             src2_zero, can_start;

    assign src1_mag  = (bus.E_signed && bus.E_src1[WIDTH-1]) ? -bus.E_src1 : bus.E_src1;
    assign src2_mag  = (bus.E_signed && bus.E_src2[WIDTH-1]) ? -bus.E_src2 : bus.E_src2;
    assign src2_zero = (bus.E_src2 == '0);
    assign can_start = (state == S_IDLE || state == S_DONE) && bus.E_start && !bus.M_abort;

    // Partial remainder stays below the divisor, so a WIDTH+1-bit difference
    // never overflows and its MSB is a clean borrow flag.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dbz    <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (can_start) begin
                        q_neg <= bus.E_signed & (bus.E_src1[WIDTH-1] ^ bus.E_src2[WIDTH-1]);
                        r_neg <= bus.E_signed & bus.E_src1[WIDTH-1];
                        dbz   <= src2_zero;
                        // Divide by zero reports the raw dividend, so keep it unmodified.
                        dvd   <= src2_zero ? bus.E_src1 : src1_mag;
                        dsr   <= src2_mag;
                        rem   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= src2_zero ? S_FIX : S_DIV;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (bus.M_abort) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                        if (cnt == '0) state <= S_FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (bus.M_abort) begin
                        state <= S_IDLE;
                    end else begin
                        if (dbz) begin
                            quot_r <= '1;
                            rem_r  <= dvd;
                            dbz_r  <= 1'b1;
                        end else begin
                            // Most-negative / -1 wraps to itself here; no trap.
                            quot_r <= q_neg ? -dvd : dvd;
                            rem_r  <= r_neg ? -rem : rem;
                            dbz_r  <= 1'b0;
                        end
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.M_div_quot    = quot_r;
    assign bus.M_div_rem     = rem_r;
    assign bus.M_div_by_zero = dbz_r;
    assign bus.M_div_busy    = (state == S_DIV) || (state == S_FIX);
    assign bus.M_div_done    = (state == S_DONE);
endmodule
